// File: rtl/operand_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : operand_skew_feeder
//  Purpose  : Diagonally skews per-beat A/B operand slices onto the left and
//             top edges of an NxN FP8 systolic array. Sequences the tile
//             clear and flags tile completion.
//  Revision : 1.0  initial release
// ============================================================================
module operand_skew_feeder #(
   parameter int N     = 4,
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_last,
   input  logic [N*8-1:0]     a_vec,
   input  logic [N*8-1:0]     b_vec,
   output logic [N*8-1:0]     a_row,
   output logic [N*8-1:0]     b_col,
   output logic               clear_out,
   output logic               busy,
   output logic               tile_done,
   output logic [CNT_W-1:0]   k_count
);

   localparam int             DW         = $clog2(2 * N);
   localparam logic [DW-1:0]  DRAIN_LOAD = DW'(2 * N - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      CLEAR  = 2'd1,
      STREAM = 2'd2,
      DRAIN  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   k_count_q, k_count_d;
   logic [DW-1:0]      drain_q, drain_d;
   logic               tile_done_q, tile_done_d;
   logic [1:0]         rst_sync_q;
   logic               rst_n_int;
   logic               accept;

   // Reset asserts asynchronously, releases two edges after rst rises.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_q <= 2'b00;
      end else begin
         rst_sync_q <= {rst_sync_q[0], 1'b1};
      end
   end

   assign rst_n_int = rst_sync_q[1];
   assign accept    = in_valid && (state_q == STREAM);

   always_comb begin
      state_d     = state_q;
      k_count_d   = k_count_q;
      drain_d     = drain_q;
      tile_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               state_d = CLEAR;
            end
         end
         CLEAR: begin
            k_count_d = '0;
            state_d   = STREAM;
         end
         STREAM: begin
            if (accept) begin
               if (k_count_q != {CNT_W{1'b1}}) begin
                  k_count_d = k_count_q + CNT_W'(1);
               end
               if (in_last) begin
                  state_d = DRAIN;
                  drain_d = DRAIN_LOAD;
               end
            end
         end
         DRAIN: begin
            // Exits on the edge where the farthest PE's c_out updates.
            if (drain_q == '0) begin
               state_d     = IDLE;
               tile_done_d = 1'b1;
            end else begin
               drain_d = drain_q - DW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n_int) begin
      if (!rst_n_int) begin
         state_q     <= IDLE;
         k_count_q   <= '0;
         drain_q     <= '0;
         tile_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_count_q   <= k_count_d;
         drain_q     <= drain_d;
         tile_done_q <= tile_done_d;
      end
   end

   assign in_ready  = (state_q == STREAM);
   assign clear_out = (state_q == CLEAR);
   assign busy      = (state_q != IDLE);
   assign tile_done = tile_done_q;
   assign k_count   = k_count_q;

   for (genvar gi = 0; gi < N; gi++) begin : g_lane
      logic [7:0] a_stg_q [gi+1];
      logic [7:0] a_stg_d [gi+1];
      logic [7:0] b_stg_q [gi+1];
      logic [7:0] b_stg_d [gi+1];

      // Cycles without an accepted beat inject FP8 zero bubbles.
      always_comb begin
         a_stg_d[0] = accept ? a_vec[8*gi +: 8] : 8'h00;
         b_stg_d[0] = accept ? b_vec[8*gi +: 8] : 8'h00;
         for (int s = 1; s <= gi; s++) begin
            a_stg_d[s] = a_stg_q[s-1];
            b_stg_d[s] = b_stg_q[s-1];
         end
      end

      always_ff @(posedge clk or negedge rst_n_int) begin
         if (!rst_n_int) begin
            for (int s = 0; s <= gi; s++) begin
               a_stg_q[s] <= 8'h00;
               b_stg_q[s] <= 8'h00;
            end
         end else begin
            for (int s = 0; s <= gi; s++) begin
               a_stg_q[s] <= a_stg_d[s];
               b_stg_q[s] <= b_stg_d[s];
            end
         end
      end

      assign a_row[8*gi +: 8] = a_stg_q[gi];
      assign b_col[8*gi +: 8] = b_stg_q[gi];
   end

endmodule
`default_nettype wire

// File: tb/tb_operand_skew_feeder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_operand_skew_feeder
//  Purpose  : Randomized self-checking bench for operand_skew_feeder against
//             a timestamp-based reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_operand_skew_feeder;

   localparam int N     = 4;
   localparam int CNT_W = 8;
   localparam int KMAX  = (1 << CNT_W) - 1;
   localparam int M_IDLE = 0, M_CLEAR = 1, M_STREAM = 2, M_DRAIN = 3;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic             in_last = 1'b0;
   logic [N*8-1:0]   a_vec = '0;
   logic [N*8-1:0]   b_vec = '0;
   logic [N*8-1:0]   a_row;
   logic [N*8-1:0]   b_col;
   logic             clear_out;
   logic             busy;
   logic             tile_done;
   logic [CNT_W-1:0] k_count;

   operand_skew_feeder #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_last   (in_last),
      .a_vec     (a_vec),
      .b_vec     (b_vec),
      .a_row     (a_row),
      .b_col     (b_col),
      .clear_out (clear_out),
      .busy      (busy),
      .tile_done (tile_done),
      .k_count   (k_count)
   );

   always #5 clk = ~clk;

   int             n_checks = 0;
   int             n_errors = 0;
   int             m_mode;
   int             k_m;
   longint         ecount = 0;
   longint         last_edge;
   bit             last_acc;
   logic [N*8-1:0] ha [N];
   logic [N*8-1:0] hb [N];

   task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, ecount);
      end
   endtask

   task automatic model_reset();
      m_mode    = M_IDLE;
      k_m       = 0;
      last_edge = -1000;
      last_acc  = 1'b0;
      for (int d = 0; d < N; d++) begin
         ha[d] = '0;
         hb[d] = '0;
      end
   endtask

   task automatic check_all(input string tag);
      logic [N*8-1:0] ea, eb;
      // Lane i shows what was injected i edges ago.
      for (int i = 0; i < N; i++) begin
         ea[8*i +: 8] = ha[i][8*i +: 8];
         eb[8*i +: 8] = hb[i][8*i +: 8];
      end
      check_val({tag, ".a_row"},     64'(a_row),     64'(ea));
      check_val({tag, ".b_col"},     64'(b_col),     64'(eb));
      check_val({tag, ".in_ready"},  64'(in_ready),  64'(m_mode == M_STREAM));
      check_val({tag, ".clear_out"}, 64'(clear_out), 64'(m_mode == M_CLEAR));
      check_val({tag, ".busy"},      64'(busy),      64'(m_mode != M_IDLE));
      check_val({tag, ".tile_done"}, 64'(tile_done), 64'(ecount == last_edge + 2*N));
      check_val({tag, ".k_count"},   64'(k_count),   64'(k_m));
   endtask

   task automatic cycle(input string tag);
      bit acc;
      @(posedge clk);
      ecount++;
      if (!rst) begin
         model_reset();
      end else begin
         acc      = (m_mode == M_STREAM) && in_valid;
         last_acc = acc;
         for (int d = N-1; d > 0; d--) begin
            ha[d] = ha[d-1];
            hb[d] = hb[d-1];
         end
         ha[0] = acc ? a_vec : '0;
         hb[0] = acc ? b_vec : '0;
         case (m_mode)
            M_IDLE:   if (in_valid) m_mode = M_CLEAR;
            M_CLEAR:  begin k_m = 0; m_mode = M_STREAM; end
            M_STREAM: if (acc) begin
                         k_m = (k_m == KMAX) ? KMAX : k_m + 1;
                         if (in_last) begin
                            m_mode    = M_DRAIN;
                            last_edge = ecount;
                         end
                      end
            default:  if (ecount == last_edge + 2*N) m_mode = M_IDLE;
         endcase
      end
      #1;
      check_all(tag);
   endtask

   function automatic logic [N*8-1:0] rand_vec();
      logic [N*8-1:0] v;
      for (int l = 0; l < N; l++) v[8*l +: 8] = 8'($urandom_range(0, 255));
      return v;
   endfunction

   task automatic send_beat(input logic [N*8-1:0] a, input logic [N*8-1:0] b, input bit last);
      bit got = 1'b0;
      in_valid = 1'b1;
      in_last  = last;
      a_vec    = a;
      b_vec    = b;
      for (int c = 0; c < 10 && !got; c++) begin
         cycle("beat");
         got = last_acc;
      end
      if (!got) check_val("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
      in_last  = 1'b0;
      a_vec    = rand_vec();
      b_vec    = rand_vec();
   endtask

   // gap < 0 picks a random 0..2 gap per beat.
   task automatic send_tile(input int nb, input int gap, input bit hold, input bit fixed);
      longint acc_edge;
      longint done_edge = -1;
      bit     seen = 1'b0;
      int     g;
      for (int b = 0; b < nb; b++) begin
         if (fixed) send_beat({N{8'h38}}, {N{8'h38}}, b == nb-1);
         else       send_beat(rand_vec(), rand_vec(), b == nb-1);
         if (b != nb-1) begin
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            for (int c = 0; c < g; c++) cycle("gap");
         end
      end
      acc_edge = ecount;
      if (hold) begin
         in_valid = 1'b1;
         in_last  = 1'($urandom_range(0, 1));
      end
      for (int c = 0; c < 2*N + 4 && !seen; c++) begin
         cycle(hold ? "drain_hold" : "drain");
         if (tile_done === 1'b1) begin
            seen      = 1'b1;
            done_edge = ecount;
         end
      end
      check_val("done_latency", 64'(done_edge - acc_edge), 64'(2*N));
      if (hold) begin
         cycle("b2b");
         in_valid = 1'b0;
         in_last  = 1'b0;
      end
   endtask

   initial begin
      model_reset();
      for (int c = 0; c < 3; c++) cycle("reset");
      rst = 1'b1;
      for (int c = 0; c < 8; c++) cycle("idle");

      send_tile(1, 0, 1'b0, 1'b1);
      for (int c = 0; c < 3; c++) cycle("idle2");

      send_tile(4, 1, 1'b0, 1'b0);
      check_val("k_count_4", 64'(k_count), 64'd4);
      cycle("idle3");

      send_tile(3, -1, 1'b1, 1'b0);
      send_tile(2, 0, 1'b0, 1'b0);
      cycle("idle4");

      send_beat(rand_vec(), rand_vec(), 1'b0);
      send_beat(rand_vec(), rand_vec(), 1'b0);
      rst = 1'b0;
      #2;
      model_reset();
      check_all("async_rst");
      for (int c = 0; c < 3; c++) cycle("in_rst");
      rst = 1'b1;
      for (int c = 0; c < 5; c++) cycle("post_rst");
      send_tile(2, 0, 1'b0, 1'b1);

      for (int t = 0; t < 8; t++) begin
         send_tile(int'($urandom_range(1, 6)), -1, 1'($urandom_range(0, 1)), 1'b0);
         for (int c = 0; c < int'($urandom_range(0, 3)); c++) cycle("rand_idle");
      end

      send_tile(260, 0, 1'b0, 1'b0);
      check_val("k_count_sat", 64'(k_count), 64'(KMAX));

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
